// File: rtl/mod_updown_counter.sv
// mod_updown_counter: bounded up/down counter with wrap or saturate behaviour and boundary pulses.
// Rev 1.0 -- initial release.
`default_nettype none

module mod_updown_counter #(
  parameter int             WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit             SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             deCount,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  logic             top_hit;
  logic             bottom_hit;
  logic [WIDTH-1:0] load_clamped;

  assign top_hit      = (out_q == MAX_VAL);
  assign bottom_hit   = (out_q == ZERO);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Single-action priority: clear, load, conflict hold, up, down, idle.
  always_comb begin
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      out_d = ZERO;
    end else if (load) begin
      out_d = load_clamped;
    end else if (count && deCount) begin
      out_d = out_q;
    end else if (count) begin
      if (top_hit) begin
        carry_d = 1'b1;
        out_d   = SATURATE ? MAX_VAL : ZERO;
      end else begin
        out_d = out_q + ONE;
      end
    end else if (deCount) begin
      if (bottom_hit) begin
        borrow_d = 1'b1;
        out_d    = SATURATE ? ZERO : MAX_VAL;
      end else begin
        out_d = out_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= ZERO;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign out    = out_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign at_max = top_hit;
  assign at_min = bottom_hit;

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench driving wrap, saturate and default-parameter counters in lockstep.
`default_nettype none

module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       count = 1'b0;
  logic       deCount = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] outv [3];
  logic [2:0] amx, amn, cy, bw;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .count(count), .deCount(deCount), .clear(clear),
    .load(load), .load_val(load_val), .out(outv[0]), .at_max(amx[0]),
    .at_min(amn[0]), .carry(cy[0]), .borrow(bw[0]));

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .count(count), .deCount(deCount), .clear(clear),
    .load(load), .load_val(load_val), .out(outv[1]), .at_max(amx[1]),
    .at_min(amn[1]), .carry(cy[1]), .borrow(bw[1]));

  mod_updown_counter u_dflt (
    .clk(clk), .reset(reset), .count(count), .deCount(deCount), .clear(clear),
    .load(load), .load_val(load_val), .out(outv[2]), .at_max(amx[2]),
    .at_min(amn[2]), .carry(cy[2]), .borrow(bw[2]));

  typedef struct packed {
    logic [2:0][3:0] val;
    logic [2:0]      carry;
    logic [2:0]      borrow;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mv   [3] = '{0, 0, 0};
  int   maxv [3] = '{9, 9, 15};
  bit   sat  [3] = '{1'b0, 1'b1, 1'b0};

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: wrap is modular arithmetic over MAX+1 values, saturate clamps.
  task automatic step(input bit rs, input bit c, input bit d, input bit clr,
                      input bit ld, input logic [3:0] lv);
    exp_t e;
    int   v, n, lvi;
    bit   pc, pb;
    @(negedge clk);
    reset = rs; count = c; deCount = d; clear = clr; load = ld; load_val = lv;
    lvi = int'(lv);
    for (int i = 0; i < 3; i++) begin
      v = mv[i]; n = v; pc = 1'b0; pb = 1'b0;
      if (rs || clr)       n = 0;
      else if (ld)         n = (lvi > maxv[i]) ? maxv[i] : lvi;
      else if (c && d)     n = v;
      else if (c) begin
        pc = (v == maxv[i]);
        n  = sat[i] ? ((v + 1 > maxv[i]) ? maxv[i] : v + 1) : (v + 1) % (maxv[i] + 1);
      end else if (d) begin
        pb = (v == 0);
        n  = sat[i] ? ((v - 1 < 0) ? 0 : v - 1) : (v + maxv[i]) % (maxv[i] + 1);
      end
      mv[i]       = n;
      e.val[i]    = 4'(n);
      e.carry[i]  = pc;
      e.borrow[i] = pb;
    end
    q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s dut%0d out", tag, i), int'(outv[i]), 0);
      chk($sformatf("%s dut%0d carry", tag, i), int'(cy[i]), 0);
      chk($sformatf("%s dut%0d borrow", tag, i), int'(bw[i]), 0);
      chk($sformatf("%s dut%0d at_min", tag, i), int'(amn[i]), 1);
      chk($sformatf("%s dut%0d at_max", tag, i), int'(amx[i]), 0);
    end
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    for (int i = 0; i < 3; i++) mv[i] = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("dut%0d out", i), int'(outv[i]), int'(e.val[i]));
          chk($sformatf("dut%0d carry", i), int'(cy[i]), int'(e.carry[i]));
          chk($sformatf("dut%0d borrow", i), int'(bw[i]), int'(e.borrow[i]));
          chk($sformatf("dut%0d at_max", i), int'(amx[i]), int'(e.val[i]) == maxv[i] ? 1 : 0);
          chk($sformatf("dut%0d at_min", i), int'(amn[i]), int'(e.val[i]) == 0 ? 1 : 0);
        end
      end
    end
  end

  initial begin : stim
    int r;
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("power_on_reset");
    step(1, 0, 0, 0, 0, 4'd0);
    step(1, 1, 1, 0, 1, 4'd5);

    // Ten increments: wrap sees 1..9,0 with carry on the wrap edge.
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 4'd0);
    // Down from zero, twice in a row to get back-to-back borrow pulses.
    step(0, 0, 0, 1, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 1, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd0);
    // Load clamping, and clear beating load on the same edge.
    step(0, 0, 0, 0, 1, 4'd13);
    step(0, 1, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 1, 4'd13);
    step(0, 0, 0, 1, 1, 4'd7);
    // Simultaneous up/down at 5 holds.
    step(0, 0, 0, 0, 1, 4'd5);
    step(0, 1, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0);
    // Default-parameter wrap from 15 and repeated saturation carries.
    step(0, 0, 0, 0, 1, 4'd15);
    step(0, 1, 0, 0, 0, 4'd0);
    step(0, 1, 0, 0, 0, 4'd0);
    // Count to 7, async reset mid-cycle, then resume counting.
    step(0, 0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 4'd0);
    async_reset();
    step(0, 1, 0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0);

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset();
        step(0, 0, 0, 0, 0, 4'd0);
      end else begin
        step(r < 4, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8,
             4'($urandom_range(0, 15)));
      end
    end

    step(0, 0, 0, 0, 0, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 1..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count  input  1  increment request, sampled on rising clk.
REQ-007 deCount  input  1  decrement request, sampled on rising clk.
REQ-008 clear  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value for load.
REQ-011 out  output  WIDTH  registered count value.
REQ-012 at_max  output  1  combinational, high when out == MAX_VAL.
REQ-013 at_min  output  1  combinational, high when out == 0.
REQ-014 carry  output  1  registered one-cycle pulse, up-boundary event.
REQ-015 borrow  output  1  registered one-cycle pulse, down-boundary event.

Function
REQ-016 Each rising clk edge SHALL apply exactly one action, in priority order: clear, load, hold-on-conflict, increment, decrement, idle hold.
REQ-017 clear=1: out SHALL become 0; carry and borrow SHALL be 0 next cycle.
REQ-018 load=1 (clear=0): out SHALL become load_val, clamped to MAX_VAL when load_val > MAX_VAL; carry/borrow SHALL be 0.
REQ-019 count=1 and deCount=1 together (no clear/load): out SHALL hold; carry/borrow SHALL be 0.
REQ-020 Increment, out < MAX_VAL: out SHALL become out+1.
REQ-021 Increment, out == MAX_VAL, SATURATE=0: out SHALL become 0 and carry SHALL be 1 for exactly the following cycle.
REQ-022 Increment, out == MAX_VAL, SATURATE=1: out SHALL hold MAX_VAL and carry SHALL be 1 for the following cycle (saturation hit reported).
REQ-023 Decrement, out > 0: out SHALL become out-1.
REQ-024 Decrement, out == 0, SATURATE=0: out SHALL become MAX_VAL and borrow SHALL be 1 for the following cycle.
REQ-025 Decrement, out == 0, SATURATE=1: out SHALL hold 0 and borrow SHALL pulse 1 cycle.
REQ-026 Repeated boundary requests on consecutive cycles SHALL produce one carry/borrow pulse per qualifying edge (back-to-back pulses allowed).
REQ-027 Latency: out, carry, borrow SHALL reflect an action one clk edge after inputs are sampled; at_max/at_min SHALL track out with zero added latency.
REQ-028 Arithmetic SHALL be WIDTH bits unsigned; out SHALL never exceed MAX_VAL.
REQ-029 Idle (no request): out SHALL hold; carry/borrow SHALL be 0.

Reset
REQ-030 reset=1 SHALL immediately, without clk, force out=0, carry=0, borrow=0; at_min=1 and at_max=0 result.
REQ-031 reset asserted mid-operation SHALL override any pending action; first post-release edge SHALL apply normal priority.
REQ-032 Deassertion of reset is synchronised externally; block needs no internal synchroniser.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-033 Reset then count=1 for 10 edges -> out 1..9,0; carry=1 only in cycle after 9->0; at_max high while out=9.
REQ-034 From out=0, deCount=1 one edge -> out=9, borrow=1 one cycle; SATURATE=1 repeat -> out stays 0, borrow pulses each edge.
REQ-035 load=1, load_val=13 -> out=9 (clamped); load with clear=1 same edge -> out=0.
REQ-036 out=5, count=1 and deCount=1 together -> out stays 5, no pulses.
REQ-037 out=7 counting, assert reset between edges -> out=0 before next edge; release, count=1 -> out=1.
REQ-038 Default parameters (MAX_VAL=15), count from 15 -> out=0, carry=1.
